parity_serial_tx: RTL and testbench

- Transmit side of the serial parity link.
- Accepts parallel data words over a valid/ready handshake and shifts each word out one bit per clock, LSB first.
- Appends a parity bit after the last data bit, so a downstream parity-tracking FSM sees a fixed parity for every frame.
- Sits between the word-producing logic and the single-bit serial line.

---
 rtl/parity_serial_tx.sv | 156 +++++++++++++++
 tb/tb_parity_serial_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : parity_serial_tx
// Description : Serial parity link transmitter. Takes parallel words over a
//               valid/ready handshake and shifts each out LSB first, one bit
//               per clock, followed by a parity bit (even or odd, selected
//               per word by odd_mode).
//               Optional macro PARITY_SERIAL_TX_START_BIT_EN prefixes every
//               frame with a start bit of 1 that is excluded from parity.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_serial_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              odd_mode,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_last,
    output logic              busy
);

    localparam int                 c_cnt_w    = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef PARITY_SERIAL_TX_START_BIT_EN
        S_START  = 2'd1,
`endif
        S_DATA   = 2'd2,
        S_PARITY = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic                tx_bit_q, tx_bit_d;
    logic                tx_valid_q, tx_valid_d;
    logic                tx_last_q, tx_last_d;
    logic                busy_q, busy_d;
    logic                accept;

    // A new word can be taken while idle or while the parity bit of the
    // previous frame is on the line, which gives zero-gap back-to-back frames.
    assign in_ready = (state_q == S_IDLE) || (state_q == S_PARITY);
    assign accept   = in_valid && in_ready;

    assign tx_bit   = tx_bit_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign busy     = busy_q;

    // Next-state / datapath logic; outputs are decoded from the next state so
    // they come straight out of flops in the cycle the state is entered.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        cnt_d      = cnt_q;
        tx_bit_d   = 1'b0;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        busy_d     = 1'b0;

        case (state_q)
            S_IDLE, S_PARITY: begin
                if (accept) begin
                    shift_d = in_data;
                    // Seeding with odd_mode makes the final accumulator the
                    // parity bit for the selected mode directly.
                    par_d   = odd_mode;
                    cnt_d   = '0;
`ifdef PARITY_SERIAL_TX_START_BIT_EN
                    state_d = S_START;
`else
                    state_d = S_DATA;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef PARITY_SERIAL_TX_START_BIT_EN
            S_START: begin
                state_d = S_DATA;
            end
`endif
            S_DATA: begin
                par_d   = par_q ^ shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + c_cnt_one;
                if (cnt_q == c_last_cnt) begin
                    state_d = S_PARITY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
`ifdef PARITY_SERIAL_TX_START_BIT_EN
            S_START: begin
                tx_bit_d   = 1'b1;
                tx_valid_d = 1'b1;
                busy_d     = 1'b1;
            end
`endif
            S_DATA: begin
                tx_bit_d   = shift_d[0];
                tx_valid_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_PARITY: begin
                tx_bit_d   = par_d;
                tx_valid_d = 1'b1;
                tx_last_d  = 1'b1;
                busy_d     = 1'b1;
            end
            default: begin
                tx_bit_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            cnt_q      <= '0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            cnt_q      <= cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            busy_q     <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_serial_tx
// Description : Self-checking bench for parity_serial_tx (DATA_W = 8).
//               Directed table of words plus randomized frames, each checked
//               cycle by cycle against a frame model built from the data word.
//               Honours PARITY_SERIAL_TX_START_BIT_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_serial_tx;

    localparam int W = 8;
`ifdef PARITY_SERIAL_TX_START_BIT_EN
    localparam int START = 1;
`else
    localparam int START = 0;
`endif
    localparam int FL = W + 1 + START;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         odd_mode = 1'b0;
    logic         tx_bit;
    logic         tx_valid;
    logic         tx_last;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    parity_serial_tx #(.DATA_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .odd_mode (odd_mode),
        .tx_bit   (tx_bit),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         odd;
        logic         exp_par;
    } vec_t;

    // Observed vector: {in_ready, busy, tx_valid, tx_last, tx_bit}
    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {rdy,busy,vld,last,bit}=%b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic logic [4:0] observe();
        return {in_ready, busy, tx_valid, tx_last, tx_bit};
    endfunction

    // Reference parity: choose p so that (ones + p) has the requested parity.
    function automatic logic model_parity(input logic [W-1:0] data, input logic odd);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += (int'(data) >> i) % 2;
        return ((ones % 2) != int'(odd));
    endfunction

    // Precondition: before a rising edge with the DUT in IDLE or PARITY.
    // Presents the word, lets it be accepted, then checks every frame cycle.
    // hold keeps in_valid high (with junk data) through the frame.
    // abort_at >= 0 pulls rst_n low during that frame cycle and stops there.
    task automatic drive_frame(input string name, input logic [W-1:0] data, input logic odd,
                               input logic exp_par, input bit hold, input int abort_at);
        logic bits [FL];
        logic [4:0] exp;
        int k = 0;
        if (START != 0) begin bits[0] = 1'b1; k = 1; end
        for (int i = 0; i < W; i++) bits[k + i] = ((int'(data) >> i) % 2) != 0;
        bits[FL-1] = exp_par;

        in_valid = 1'b1;
        in_data  = data;
        odd_mode = odd;
        @(posedge clk);
        #1;
        in_valid = hold;
        for (int i = 0; i < FL; i++) begin
            in_data  = W'($urandom);
            odd_mode = 1'($urandom);
            @(negedge clk);
            exp = {(i == FL-1), 1'b1, 1'b1, (i == FL-1), bits[i]};
            check($sformatf("%s bit%0d", name, i), observe(), exp);
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check($sformatf("%s async reset", name), observe(), 5'b10000);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic idle_cycle(input string name);
        in_valid = 1'b0;
        @(negedge clk);
        check(name, observe(), 5'b10000);
    endtask

    vec_t table_v[$];

    initial begin
        // Directed vectors: {data, odd_mode, expected parity bit}
        table_v.push_back('{8'hA5, 1'b0, 1'b0});
        table_v.push_back('{8'h07, 1'b0, 1'b1});
        table_v.push_back('{8'h07, 1'b1, 1'b0});
        table_v.push_back('{8'h00, 1'b1, 1'b1});
        table_v.push_back('{8'h80, 1'b0, 1'b1});
        table_v.push_back('{8'hFF, 1'b1, 1'b1});
        table_v.push_back('{8'h3C, 1'b0, 1'b0});

        // Reset held: outputs idle, ready high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset hold %0d", i), observe(), 5'b10000);
        end
        rst_n = 1'b1;

        // First accept must happen on the first edge after release.
        drive_frame("first after reset", 8'hA5, 1'b0, 1'b0, 1'b0, -1);
        idle_cycle("idle after first");

        for (int v = 0; v < table_v.size(); v++) begin
            drive_frame($sformatf("table%0d %h/%0d", v, table_v[v].data, table_v[v].odd),
                        table_v[v].data, table_v[v].odd, table_v[v].exp_par, 1'b0, -1);
            idle_cycle($sformatf("table%0d idle", v));
        end

        // Back-to-back: 0xFF then 0x01 with in_valid held, no gap.
        drive_frame("b2b FF", 8'hFF, 1'b0, 1'b0, 1'b1, -1);
        drive_frame("b2b 01", 8'h01, 1'b0, 1'b1, 1'b0, -1);
        idle_cycle("b2b idle");
        idle_cycle("b2b idle2");

        // Reset during data bit 4 of 0x3C, then a clean 0x3C frame.
        drive_frame("abort 3C", 8'h3C, 1'b0, 1'b0, 1'b1, 4 + START);
        @(negedge clk);
        check("abort reset low", observe(), 5'b10000);
        rst_n = 1'b1;
        idle_cycle("abort release idle");
        drive_frame("after abort 3C", 8'h3C, 1'b0, 1'b0, 1'b0, -1);
        idle_cycle("after abort idle");

        // Randomized frames against the parity model, random back-to-back.
        begin
            bit prev_hold = 1'b0;
            for (int r = 0; r < 24; r++) begin
                logic [W-1:0] d = W'($urandom);
                logic         o = 1'($urandom);
                bit           h = (r != 23) && ($urandom_range(0, 2) == 0);
                drive_frame($sformatf("rand%0d %h/%0d", r, d, o), d, o, model_parity(d, o), h, -1);
                if (!h) begin
                    int gaps = $urandom_range(1, 3);
                    for (int g = 0; g < gaps; g++) idle_cycle($sformatf("rand%0d idle%0d", r, g));
                end
                prev_hold = h;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
